// File: rtl/bcd_counter_pkg.sv
// Shared types and helpers for the N-digit radix-R counter.
// Digit-range checks live here so the cell and the top agree on what "valid" means.
package bcd_counter_pkg;

   localparam int RADIX_DEC   = 10;
   localparam int RADIX_HEX   = 16;
   localparam int DIGIT_W_DEF = 5;

   typedef logic [DIGIT_W_DEF-1:0] digit_t;

   function automatic logic is_valid_digit(input int unsigned value, input int unsigned radix);
      return value < radix;
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One digit register of the counter: load, step up/down with wrap at the radix,
// and flags telling the neighbouring cells whether this digit sits at an end.
module bcd_digit_cell
   import bcd_counter_pkg::*;
#(
   parameter int RADIX   = RADIX_DEC,
   parameter int DIGIT_W = DIGIT_W_DEF
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               step_i,
   input  logic               up_i,
   input  logic               load_i,
   input  logic [DIGIT_W-1:0] load_val_i,
   output logic [DIGIT_W-1:0] digit_o,
   output logic               at_max_o,
   output logic               at_min_o
);

   localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(RADIX - 1);

   logic [DIGIT_W-1:0] digit_q, digit_d;

   assign at_max_o = (digit_q == DIGIT_MAX);
   assign at_min_o = (digit_q == '0);
   assign digit_o  = digit_q;

   always_comb begin
      digit_d = digit_q;
      if (load_i) begin
         digit_d = load_val_i;
      end else if (step_i) begin
         if (up_i) digit_d = at_max_o ? '0 : digit_q + 1'b1;
         else      digit_d = at_min_o ? DIGIT_MAX : digit_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) digit_q <= '0;
      else       digit_q <= digit_d;
   end

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit radix-R up/down counter with load, wrap/saturate and terminal-count pulse.
// The carry/borrow chain is the AND of lower cells' end flags; the chain's tail marks the terminal state.
module bcd_counter_n
   import bcd_counter_pkg::*;
#(
   parameter int DIGITS  = 4,
   parameter int RADIX   = RADIX_DEC,
   parameter int DIGIT_W = DIGIT_W_DEF
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      EN,
   input  logic                      UP,
   input  logic                      SAT,
   input  logic                      LOAD,
   input  logic [DIGITS*DIGIT_W-1:0] LOAD_VAL,
   output logic [DIGITS*DIGIT_W-1:0] DIGIT,
   output logic                      TC,
   output logic                      ZERO,
   output logic                      LOAD_ERR
);

   logic [DIGITS:0]                chain;
   logic [DIGITS-1:0]              at_max, at_min, field_bad;
   logic [DIGITS*DIGIT_W-1:0]      load_clamped;
   logic                           terminal, count_ok;
   logic                           tc_q, tc_d;
   logic                           load_err_q, load_err_d;

   assign chain[0] = 1'b1;
   assign terminal = chain[DIGITS];
   // At a saturating end the whole step is suppressed, so no cell moves.
   assign count_ok = EN & ~LOAD & ~(SAT & terminal);

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         logic [DIGIT_W-1:0] field;
         assign field = LOAD_VAL[gi*DIGIT_W +: DIGIT_W];
         assign field_bad[gi] = ~is_valid_digit(32'(field), RADIX);
         assign load_clamped[gi*DIGIT_W +: DIGIT_W] = field_bad[gi] ? DIGIT_W'(RADIX - 1) : field;
         assign chain[gi+1] = chain[gi] & (UP ? at_max[gi] : at_min[gi]);

         bcd_digit_cell #(
            .RADIX   (RADIX),
            .DIGIT_W (DIGIT_W)
         ) u_cell (
            .clk_i      (CLK),
            .rst_i      (RST),
            .step_i     (count_ok & chain[gi]),
            .up_i       (UP),
            .load_i     (LOAD),
            .load_val_i (load_clamped[gi*DIGIT_W +: DIGIT_W]),
            .digit_o    (DIGIT[gi*DIGIT_W +: DIGIT_W]),
            .at_max_o   (at_max[gi]),
            .at_min_o   (at_min[gi])
         );
      end
   endgenerate

   always_comb begin
      tc_d       = EN & ~LOAD & terminal;
      load_err_d = load_err_q | (LOAD & (|field_bad));
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         tc_q       <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         tc_q       <= tc_d;
         load_err_q <= load_err_d;
      end
   end

   assign TC       = tc_q;
   assign LOAD_ERR = load_err_q;
   assign ZERO     = (DIGIT == '0);

endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: directed scenarios plus randomized controls, checked
// against an integer-valued model of the count (value in 0..RADIX**DIGITS-1).
module tb_bcd_counter_n;
   import bcd_counter_pkg::*;

   localparam int DIGITS = 4;
   localparam int RADIX  = RADIX_DEC;
   localparam int DW     = DIGIT_W_DEF;
   localparam int W      = DIGITS * DW;

   logic          clk = 1'b0;
   logic          rst, en, up, sat, load;
   logic [W-1:0]  load_val;
   logic [W-1:0]  digit;
   logic          tc, zero, load_err;

   int n_cmp = 0;
   int n_bad = 0;

   int m_val = 0;
   int m_max;
   bit m_tc  = 1'b0;
   bit m_err = 1'b0;

   always #5 clk = ~clk;

   bcd_counter_n #(
      .DIGITS  (DIGITS),
      .RADIX   (RADIX),
      .DIGIT_W (DW)
   ) dut (
      .CLK      (clk),
      .RST      (rst),
      .EN       (en),
      .UP       (up),
      .SAT      (sat),
      .LOAD     (load),
      .LOAD_VAL (load_val),
      .DIGIT    (digit),
      .TC       (tc),
      .ZERO     (zero),
      .LOAD_ERR (load_err)
   );

   function automatic logic [W-1:0] to_bus(input int v);
      logic [W-1:0] r;
      int           x;
      r = '0;
      x = v;
      for (int k = 0; k < DIGITS; k++) begin
         r[k*DW +: DW] = DW'(x % RADIX);
         x = x / RADIX;
      end
      return r;
   endfunction

   function automatic int from_fields(input logic [W-1:0] lv, output bit err);
      int v, mult, f;
      v    = 0;
      mult = 1;
      err  = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         f = int'(lv[k*DW +: DW]);
         if (f >= RADIX) begin
            f   = RADIX - 1;
            err = 1'b1;
         end
         v    = v + f * mult;
         mult = mult * RADIX;
      end
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Apply one set of controls across a rising edge, update the model, check at the falling edge.
   task automatic cyc(input string tag, input bit r, input bit e, input bit u,
                      input bit s, input bit l, input logic [W-1:0] lv);
      bit b;
      rst = r; en = e; up = u; sat = s; load = l; load_val = lv;
      @(posedge clk);
      if (r) begin
         m_val = 0; m_tc = 1'b0; m_err = 1'b0;
      end else if (l) begin
         m_val = from_fields(lv, b);
         m_err = m_err | b;
         m_tc  = 1'b0;
      end else if (e) begin
         if (u) begin
            if (m_val == m_max) begin m_tc = 1'b1; if (!s) m_val = 0; end
            else begin m_val = m_val + 1; m_tc = 1'b0; end
         end else begin
            if (m_val == 0) begin m_tc = 1'b1; if (!s) m_val = m_max; end
            else begin m_val = m_val - 1; m_tc = 1'b0; end
         end
      end else begin
         m_tc = 1'b0;
      end
      @(negedge clk);
      check({tag, ".digit"}, 32'(digit), 32'(to_bus(m_val)));
      check({tag, ".tc"}, 32'(tc), 32'(m_tc));
      check({tag, ".zero"}, 32'(zero), 32'(m_val == 0));
      check({tag, ".load_err"}, 32'(load_err), 32'(m_err));
      $display("%s r=%0b e=%0b u=%0b s=%0b l=%0b lv=%h -> digit=%h tc=%0b zero=%0b err=%0b",
               tag, r, e, u, s, l, lv, digit, tc, zero, load_err);
   endtask

   initial begin
      logic [W-1:0] lv;
      int           pick;
      m_max = 1;
      for (int k = 0; k < DIGITS; k++) m_max = m_max * RADIX;
      m_max = m_max - 1;
      rst = 1'b0; en = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0; load_val = '0;
      @(negedge clk);

      // Reset held two cycles with EN active.
      cyc("t1_rst", 1, 1, 1, 0, 0, '0);
      cyc("t1_rst", 1, 1, 1, 0, 0, '0);

      // 1000 up steps from zero.
      for (int i = 0; i < 1000; i++) cyc("t2_up", 0, 1, 1, 0, 0, '0);
      check("t2_1000", 32'(digit), 32'h0000_8000);

      // Wrap from max with TC for exactly one cycle.
      cyc("t3_load", 0, 0, 1, 0, 1, to_bus(9999));
      cyc("t3_wrap", 0, 1, 1, 0, 0, '0);
      check("t3_tc_hi", 32'(tc), 32'd1);
      cyc("t3_idle", 0, 0, 1, 0, 0, '0);
      check("t3_tc_lo", 32'(tc), 32'd0);

      // Saturate at zero counting down.
      cyc("t4_load", 0, 0, 0, 1, 1, to_bus(0));
      for (int i = 0; i < 3; i++) begin
         cyc("t4_sat", 0, 1, 0, 1, 0, '0);
         check("t4_tc", 32'(tc), 32'd1);
      end

      // Out-of-range field clamps and sets the sticky error.
      lv = to_bus(0);
      lv[DW-1:0] = DW'(12);
      cyc("t5_load", 0, 0, 1, 0, 1, lv);
      check("t5_d0", 32'(digit[DW-1:0]), 32'd9);
      for (int i = 0; i < 5; i++) cyc("t5_hold", 0, 1, 1, 0, 0, '0);
      check("t5_sticky", 32'(load_err), 32'd1);
      cyc("t5_load_ok", 0, 0, 1, 0, 1, to_bus(3));
      check("t5_sticky2", 32'(load_err), 32'd1);

      // Reset mid-count beats EN; LOAD beats EN.
      cyc("t6_rst", 1, 0, 1, 0, 0, '0);
      check("t6_err_clr", 32'(load_err), 32'd0);
      for (int i = 0; i < 457; i++) cyc("t6_up", 0, 1, 1, 0, 0, '0);
      check("t6_457", 32'(digit), 32'(to_bus(457)));
      cyc("t6_rst_en", 1, 1, 1, 0, 0, '0);
      check("t6_zero", 32'(digit), 32'd0);
      cyc("t6_load_en", 0, 1, 0, 0, 1, to_bus(100));
      check("t6_0100", 32'(digit), 32'(to_bus(100)));

      // Randomized controls, biased toward the terminal values.
      for (int i = 0; i < 3000; i++) begin
         pick = int'($urandom_range(0, 5));
         case (pick)
            0: lv = to_bus(0);
            1: lv = to_bus(m_max);
            2: lv = to_bus(m_max - 1);
            3: lv = to_bus(1);
            default: lv = W'($urandom);
         endcase
         cyc("rnd", ($urandom % 97) == 0, ($urandom % 4) != 0, $urandom % 2 == 1,
             $urandom % 2 == 1, ($urandom % 12) == 0, lv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
